// File: rtl/ysyx_22050535_lsu.sv
// Load/store unit sitting between the execute stage and write-back.
//
// Accepts one op at a time from the execute stage. Loads and stores run a
// request/response transaction on the data-memory bus. All other ops pass the
// execute result straight through. The formatted result goes to the WBU over
// a valid/ready handshake.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_*                upstream op: valid/ready, opcode, func3, addr, wdata, rd
//   out_*               write-back bundle: valid/ready, result, rd, wen, fault
//   mem_req_*           bus request: valid/ready, wen, word address, lane data, mask
//   mem_resp_valid      one-cycle read-data / write-ack pulse
//   mem_rdata           read data word
module ysyx_22050535_lsu #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_func3,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [4:0]            in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_rd,
  output logic                  out_wen,
  output logic                  out_fault,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [6:0]  OpLoad   = 7'b0000011;
  localparam logic [6:0]  OpStore  = 7'b0100011;
  localparam logic [6:0]  OpBranch = 7'b1100011;
  // Last WAIT cycle index before a timeout fault is raised.
  localparam logic [31:0] LastCnt  = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [2:0]            func3_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic [4:0]            rd_q;
  logic                  store_q;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  wen_q, wen_d;
  logic                  fault_q, fault_d;

  // Decode of the incoming op, used only on the acceptance cycle.
  logic in_is_load, in_is_store, in_legal, in_aligned, accept;

  always_comb begin
    in_is_load  = (in_opcode == OpLoad);
    in_is_store = (in_opcode == OpStore);
    in_legal    = 1'b0;
    if (in_is_load) begin
      in_legal = (in_func3 == 3'b000) || (in_func3 == 3'b001) || (in_func3 == 3'b010) ||
                 (in_func3 == 3'b100) || (in_func3 == 3'b101);
    end else if (in_is_store) begin
      in_legal = (in_func3 == 3'b000) || (in_func3 == 3'b001) || (in_func3 == 3'b010);
    end
    // func3[1:0] encodes the access size for every legal load/store width.
    unique case (in_func3[1:0])
      2'b01:   in_aligned = (in_addr[0] == 1'b0);
      2'b10:   in_aligned = (in_addr[1:0] == 2'b00);
      default: in_aligned = 1'b1;
    endcase
    accept = (state_q == StIdle) && in_valid;
  end

  // Lane shift for the latched address.
  logic [4:0]            sh;
  logic [DATA_WIDTH-1:0] rd_shifted, load_fmt, st_wdata;
  logic [3:0]            st_mask;

  always_comb begin
    sh         = {addr_q[1:0], 3'b000};
    rd_shifted = mem_rdata >> sh;
    unique case (func3_q)
      3'b000:  load_fmt = {{(DATA_WIDTH-8){rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_fmt = {{(DATA_WIDTH-16){rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, rd_shifted[7:0]};
      3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, rd_shifted[15:0]};
      default: load_fmt = rd_shifted;
    endcase
    unique case (func3_q[1:0])
      2'b00: begin
        st_wdata = {{(DATA_WIDTH-8){1'b0}}, wdata_q[7:0]} << sh;
        st_mask  = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_wdata = {{(DATA_WIDTH-16){1'b0}}, wdata_q[15:0]} << sh;
        st_mask  = 4'b0011 << addr_q[1:0];
      end
      default: begin
        st_wdata = wdata_q;
        st_mask  = 4'b1111;
      end
    endcase
  end

  // Next-state and write-back bundle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    wen_d    = wen_q;
    fault_d  = fault_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_is_load || in_is_store) begin
            if (in_legal && in_aligned) begin
              state_d = StReq;
            end else begin
              state_d  = StDone;
              result_d = '0;
              wen_d    = 1'b0;
              fault_d  = 1'b1;
            end
          end else begin
            state_d  = StDone;
            result_d = in_addr;
            wen_d    = (in_opcode != OpBranch);
            fault_d  = 1'b0;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        // A response arriving on the timeout cycle still wins.
        if (mem_resp_valid) begin
          state_d = StDone;
          fault_d = 1'b0;
          if (store_q) begin
            result_d = '0;
            wen_d    = 1'b0;
          end else begin
            result_d = load_fmt;
            wen_d    = (rd_q != 5'd0);
          end
        end else if (cnt_q >= LastCnt) begin
          state_d  = StDone;
          result_d = '0;
          wen_d    = 1'b0;
          fault_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      func3_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      store_q  <= 1'b0;
      result_q <= '0;
      wen_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      wen_q    <= wen_d;
      fault_q  <= fault_d;
      if (accept) begin
        func3_q <= in_func3;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        rd_q    <= in_rd;
        store_q <= in_is_store;
      end
    end
  end

  // Bus fields are only driven while a request is pending.
  always_comb begin
    in_ready      = (state_q == StIdle);
    mem_req_valid = (state_q == StReq);
    mem_wen       = mem_req_valid && store_q;
    mem_addr      = mem_req_valid ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    mem_wdata     = mem_wen ? st_wdata : '0;
    mem_wmask     = mem_wen ? st_mask : 4'b0000;
    out_valid     = (state_q == StDone);
    out_result    = result_q;
    out_rd        = rd_q;
    out_wen       = wen_q;
    out_fault     = fault_q;
  end

endmodule

// File: tb/tb_ysyx_22050535_lsu.sv
// Self-checking bench for ysyx_22050535_lsu: directed cases followed by
// random ops, every result compared against a behavioural model.
module tb_ysyx_22050535_lsu;

  localparam int unsigned To = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen, out_fault;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22050535_lsu #(
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_func3      (in_func3),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_rd         (in_rd),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_wen       (out_wen),
    .out_fault     (out_fault),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          bus;
    bit          is_st;
    logic [31:0] res;
    bit          wen;
    bit          fault;
    logic [3:0]  mask;
    logic [31:0] mwdata;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: access size in bytes, alignment by modulo, lane selection by
  // byte arithmetic, sign extension by subtracting 2^bits.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input logic [31:0] rdata);
    exp_t   e;
    int     size;
    int     off;
    longint one = 1;
    longint v;
    bit     is_ld = (op == 7'h03);
    e.is_st  = (op == 7'h23);
    e.mask   = 4'h0;
    e.mwdata = 32'h0;
    e.bus    = 1'b0;
    if (!is_ld && !e.is_st) begin
      e.res   = addr;
      e.wen   = (op != 7'h63);
      e.fault = 1'b0;
      return e;
    end
    size = 0;
    if (is_ld) begin
      if (f3 == 0 || f3 == 4) size = 1;
      else if (f3 == 1 || f3 == 5) size = 2;
      else if (f3 == 2) size = 4;
    end else begin
      if (f3 == 0) size = 1;
      else if (f3 == 1) size = 2;
      else if (f3 == 2) size = 4;
    end
    if (size == 0 || (addr % size) != 0) begin
      e.res   = 32'h0;
      e.wen   = 1'b0;
      e.fault = 1'b1;
      return e;
    end
    off     = int'(addr % 4);
    e.bus   = 1'b1;
    e.fault = 1'b0;
    if (e.is_st) begin
      e.mask   = 4'(((one << size) - 1) << off);
      e.mwdata = 32'((longint'(wdata) % (one << (8 * size))) << (8 * off));
      e.res    = 32'h0;
      e.wen    = 1'b0;
    end else begin
      v = (longint'(rdata) >> (8 * off)) % (one << (8 * size));
      if (f3 < 4 && size < 4 && v >= (one << (8 * size - 1))) v = v - (one << (8 * size));
      e.res = 32'(v);
      e.wen = (rd != 5'd0);
    end
    return e;
  endfunction

  // One full transaction. resp_lat < 0 means the memory never answers.
  task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input int req_dly, input int resp_lat, input int out_dly,
                        input bit hammer);
    exp_t e = model(op, f3, addr, wdata, rd, rdata);
    int   waits;
    check({tag, ".idle_rdy"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_opcode = op;
    in_func3  = f3;
    in_addr   = addr;
    in_wdata  = wdata;
    in_rd     = rd;
    step();
    in_valid = hammer;
    if (hammer) begin
      in_opcode = 7'h33;
      in_addr   = $urandom;
      in_wdata  = $urandom;
      in_rd     = 5'(~rd);
    end
    if (e.bus) begin
      for (int i = 0; i <= req_dly; i++) begin
        check({tag, ".req_v"}, 32'(mem_req_valid), 32'd1);
        check({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, ".mwen"}, 32'(mem_wen), 32'(e.is_st));
        check({tag, ".wdata"}, mem_wdata, e.mwdata);
        check({tag, ".mask"}, 32'(mem_wmask), 32'(e.mask));
        check({tag, ".busy_rdy"}, 32'(in_ready), 32'd0);
        check({tag, ".early_ov"}, 32'(out_valid), 32'd0);
        if (i == req_dly) mem_req_ready = 1'b1;
        step();
      end
      mem_req_ready = 1'b0;
      check({tag, ".req_drop"}, 32'(mem_req_valid), 32'd0);
      if (resp_lat >= 0) begin
        for (int i = 0; i < resp_lat; i++) begin
          check({tag, ".wait_ov"}, 32'(out_valid), 32'd0);
          step();
        end
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
        step();
        mem_resp_valid = 1'b0;
        mem_rdata      = $urandom;
      end else begin
        waits = 1;
        while (!out_valid && waits < 50) begin
          step();
          if (!out_valid) waits++;
        end
        check({tag, ".to_cycles"}, 32'(waits), 32'(To));
        e.res   = 32'h0;
        e.wen   = 1'b0;
        e.fault = 1'b1;
      end
    end
    for (int i = 0; i <= out_dly; i++) begin
      check({tag, ".ov"}, 32'(out_valid), 32'd1);
      check({tag, ".res"}, out_result, e.res);
      check({tag, ".wen"}, 32'(out_wen), 32'(e.wen));
      check({tag, ".fault"}, 32'(out_fault), 32'(e.fault));
      check({tag, ".rd"}, 32'(out_rd), 32'(rd));
      check({tag, ".done_rdy"}, 32'(in_ready), 32'd0);
      check({tag, ".done_req"}, 32'(mem_req_valid), 32'd0);
      if (i == out_dly) out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, ".drain_ov"}, 32'(out_valid), 32'd0);
    check({tag, ".drain_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    int          sel;
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_opcode      = '0;
    in_func3       = '0;
    in_addr        = '0;
    in_wdata       = '0;
    in_rd          = '0;
    out_ready      = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    step();
    step();
    rst = 1'b0;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.req_valid", 32'(mem_req_valid), 32'd0);
    check("rst.result", out_result, 32'h0);
    check("rst.wen", 32'(out_wen), 32'd0);
    check("rst.fault", 32'(out_fault), 32'd0);
    check("rst.mask", 32'(mem_wmask), 32'd0);

    run_op("add", 7'h33, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 32'h0, 0, 0, 0, 0);
    run_op("lb", 7'h03, 3'd0, 32'h8000_0003, 32'h0, 5'd3, 32'h80FF_FF7F, 0, 0, 0, 0);
    run_op("lbu", 7'h03, 3'd4, 32'h8000_0003, 32'h0, 5'd4, 32'h80FF_FF7F, 0, 0, 0, 0);
    run_op("sh", 7'h23, 3'd1, 32'h8000_0002, 32'hDEAD_BEEF, 5'd0, 32'h0, 0, 0, 0, 0);
    run_op("bp_sw", 7'h23, 3'd2, 32'h8000_0010, 32'h1234_5678, 5'd7, 32'h0, 4, 1, 3, 1);
    run_op("bp_lhu", 7'h03, 3'd5, 32'h8000_0012, 32'h0, 5'd9, 32'hA5B6_C7D8, 4, 0, 3, 1);
    run_op("lw_mis", 7'h03, 3'd2, 32'h8000_0002, 32'h0, 5'd6, 32'h0, 0, 0, 0, 0);
    run_op("ld_f3", 7'h03, 3'd3, 32'h8000_0000, 32'h0, 5'd6, 32'h0, 0, 0, 0, 0);
    run_op("sb_f3", 7'h23, 3'd4, 32'h8000_0000, 32'h0, 5'd6, 32'h0, 0, 0, 0, 0);
    run_op("tmo", 7'h03, 3'd2, 32'h8000_0004, 32'h0, 5'd8, 32'h0, 0, -1, 1, 0);
    run_op("coinc", 7'h03, 3'd1, 32'h8000_0006, 32'h0, 5'd8, 32'h8001_0000, 0, 3, 0, 0);
    run_op("branch", 7'h63, 3'd1, 32'hCAFE_0000, 32'h0, 5'd2, 32'h0, 0, 0, 0, 0);
    run_op("lw_x0", 7'h03, 3'd2, 32'h8000_0008, 32'h0, 5'd0, 32'h1357_9BDF, 0, 1, 0, 0);
    run_op("sb_lane", 7'h23, 3'd0, 32'h8000_0001, 32'h0000_00AB, 5'd1, 32'h0, 1, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 5);
      unique case (sel)
        0, 1:    op = 7'h03;
        2, 3:    op = 7'h23;
        4:       op = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13;
        default: op = 7'h63;
      endcase
      f3 = 3'($urandom_range(0, 5));
      run_op($sformatf("rnd%0d", n), op, f3, $urandom, $urandom, 5'($urandom),
             $urandom, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end

    // Reset while waiting on the bus, then a stale response.
    in_valid  = 1'b1;
    in_opcode = 7'h03;
    in_func3  = 3'd2;
    in_addr   = 32'h8000_0008;
    in_rd     = 5'd4;
    step();
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("rw.in_wait", 32'(mem_req_valid), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rw.in_ready", 32'(in_ready), 32'd1);
    check("rw.out_valid", 32'(out_valid), 32'd0);
    check("rw.req_valid", 32'(mem_req_valid), 32'd0);
    check("rw.result", out_result, 32'h0);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hFFFF_FFFF;
    step();
    mem_resp_valid = 1'b0;
    check("rw.stale_ov", 32'(out_valid), 32'd0);
    check("rw.stale_rdy", 32'(in_ready), 32'd1);
    step();
    check("rw.stale_ov2", 32'(out_valid), 32'd0);
    run_op("post_rst", 7'h33, 3'd0, 32'h0000_BEEF, 32'h0, 5'd11, 32'h0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050535_lsu.md
Name: ysyx_22050535_lsu

Overview:
- Load/store stage directly downstream of the execute unit in the NPC core.
- Takes the execute result (effective address or ALU value), the store data and the decoded opcode/func3.
- Runs a multi-cycle request/response transaction on a simple data-memory bus for loads and stores, and passes non-memory results through.
- Hands a formatted write-back value to the WBU over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, datapath and address width.
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before a bus fault is reported; must be ≥1.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream op valid
- in_ready  output  1  LSU can accept an op
- in_opcode  input  7  instruction opcode
- in_func3  input  3  instruction func3
- in_addr  input  DATA_WIDTH  execute result; effective address for load/store
- in_wdata  input  DATA_WIDTH  store data (rs2 value)
- in_rd  input  5  destination register
- out_valid  output  1  write-back bundle valid
- out_ready  input  1  WBU accepts bundle
- out_result  output  DATA_WIDTH  write-back value
- out_rd  output  5  destination register
- out_wen  output  1  register write enable
- out_fault  output  1  misaligned, illegal-width or timed-out access
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts request
- mem_wen  output  1  1 = store, 0 = load
- mem_addr  output  DATA_WIDTH  word-aligned address {addr[31:2],2'b00}
- mem_wdata  output  DATA_WIDTH  lane-shifted store data
- mem_wmask  output  4  byte-lane write mask
- mem_resp_valid  input  1  read data / write acknowledge valid, one-cycle pulse
- mem_rdata  input  DATA_WIDTH  read data word

Behaviour:
- States:
  - IDLE: in_ready=1.
  - REQ: mem_req_valid=1.
  - WAIT: awaiting mem_resp_valid.
  - DONE: out_valid=1.
- in_ready is 1 only in IDLE. No op is accepted in the same cycle DONE is drained.
- Reset (any state, including mid-transaction): next state IDLE. All outputs are 0 except in_ready=1. Timeout counter is cleared. A mem_resp_valid arriving in IDLE is ignored.
- Op acceptance (IDLE & in_valid): latch opcode, func3, addr, wdata, rd.
- Load opcode 7'b0000011, store opcode 7'b0100011:
  - Legal and aligned → REQ.
  - Otherwise → DONE with out_fault=1, out_wen=0, out_result=0, and no bus request.
- Legal widths:
  - Load func3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store func3: 000 SB, 001 SH, 010 SW.
  - Any other func3 is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- Any other opcode → DONE with out_result=in_addr and out_fault=0. out_wen=0 for branch 7'b1100011, else out_wen=1.
- REQ:
  - mem_req_valid, mem_addr, mem_wen, mem_wdata and mem_wmask are held stable until mem_req_ready.
  - On the handshake cycle: → WAIT, timeout counter=0.
- Memory is guaranteed to respond no earlier than the cycle after acceptance.
- Store lanes (sh = addr[1:0]×8):
  - SB: mask 4'b0001<<addr[1:0], wdata = in_wdata[7:0]<<sh.
  - SH: mask 4'b0011<<addr[1:0], wdata = in_wdata[15:0]<<sh.
  - SW: mask 4'b1111, wdata unshifted.
- Loads drive mask 4'b0000 and mem_wen=0.
- WAIT:
  - Counter increments each cycle.
  - On mem_resp_valid → DONE.
  - If counter reaches TIMEOUT_CYCLES without a response → DONE, out_fault=1, out_wen=0, out_result=0.
  - If response and timeout coincide, the response wins.
- Load formatting (mem_rdata>>sh, then extend):
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW takes the word unmodified.
  - out_wen = (in_rd≠0).
- Store completion: out_result=0, out_wen=0; mem_rdata is ignored.
- DONE: out_* registered and held stable while out_valid=1 and out_ready=0. On out_ready → IDLE, out_valid=0 the next cycle.
- Latency from acceptance in cycle N:
  - Non-memory or fault: out_valid at N+1.
  - Memory with mem_req_ready=1 at N+1 and response at N+2: out_valid at N+3.

Test Plan:
- Non-memory pass-through: ADD opcode 0110011, in_addr=0x1234, rd=5 → out_valid at N+1, out_result=0x1234, out_wen=1, no mem_req_valid.
- LB: addr=0x8000_0003, mem_rdata=0x80FF_FF7F → mem_addr=0x8000_0000, out_result=0xFFFF_FF80. LBU of the same word → 0x0000_0080.
- SH: addr=0x8000_0002, wdata=0xDEAD_BEEF → mem_wmask=4'b1100, mem_wdata=0xBEEF_0000, mem_wen=1, out_wen=0.
- Backpressure: hold mem_req_ready=0 for 4 cycles, then out_ready=0 for 3 cycles → request fields and out_* stable throughout, in_ready=0, single transaction only.
- Faults:
  - LW at 0x8000_0002 → out_fault=1 at N+1, no bus request.
  - Load func3=011 → out_fault=1.
  - No response with TIMEOUT_CYCLES=4 → out_fault=1 after 4 WAIT cycles.
- Reset in WAIT: assert rst for one cycle → state IDLE and in_ready=1. A later stale mem_resp_valid produces no out_valid.
